// File: rtl/updown_ctrl.sv
// Direction controller for the sync_updown counter: manual button control or ping-pong sweep.
// Define UPDOWN_CTRL_DEBOUNCE_EN to build the per-button debouncers; otherwise the synchronizer output is used directly.
module updown_ctrl #(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_btn,
  input  logic             dn_btn,
  input  logic             mode,
  input  logic [WIDTH-1:0] q,
  output logic             updown,
  output logic             dir_chg
);

  typedef enum logic {DN = 1'b0, UP = 1'b1} dir_e;

  localparam logic [WIDTH-1:0] Q_HI = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] Q_LO = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0] btn_s;
  logic [1:0] sync1_r;
  logic [1:0] sync2_r;
  logic [1:0] deb_s;
  logic [1:0] deb_d_r;
  logic [1:0] rise_s;
  dir_e       state_r;
  dir_e       state_nxt_s;
  logic       dir_chg_r;

  // bit 0 = up request, bit 1 = down request
  assign btn_s = {dn_btn, up_btn};

  // two-flop synchronizer per button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef UPDOWN_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0][CNT_W-1:0] cnt_r;
  logic [1:0]            deb_r;

  // debounce: level flips only after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      deb_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_MAX) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign deb_s = deb_r;
`else
  assign deb_s = sync2_r;
`endif

  // delayed debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_d_r <= 2'b00;
    end else begin
      deb_d_r <= deb_s;
    end
  end

  assign rise_s = deb_s & ~deb_d_r;

  // next direction: ping-pong turns one count early so the counter never wraps
  always_comb begin
    state_nxt_s = state_r;
    if (mode) begin
      case (state_r)
        UP: begin
          if (q >= Q_HI) state_nxt_s = DN;
          else           state_nxt_s = UP;
        end
        DN: begin
          if (q <= Q_LO) state_nxt_s = UP;
          else           state_nxt_s = DN;
        end
        default: state_nxt_s = UP;
      endcase
    end else begin
      case (rise_s)
        2'b01:   state_nxt_s = UP;
        2'b10:   state_nxt_s = DN;
        default: state_nxt_s = state_r;
      endcase
    end
  end

  // direction state and change pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= UP;
      dir_chg_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dir_chg_r <= (state_nxt_s != state_r);
    end
  end

  assign updown  = state_r;
  assign dir_chg = dir_chg_r;

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed self-checking bench for updown_ctrl, with a behavioural 3-bit up/down counter closing the q loop.
module tb_updown_ctrl;

`ifdef UPDOWN_CTRL_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_btn = 1'b0;
  logic       dn_btn = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] q;
  logic       updown;
  logic       dir_chg;

  int total = 0;
  int bad = 0;

  updown_ctrl #(.WIDTH(3), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_btn  (up_btn),
    .dn_btn  (dn_btn),
    .mode    (mode),
    .q       (q),
    .updown  (updown),
    .dir_chg (dir_chg)
  );

  always #5 clk = ~clk;

  // stand-in for sync_updown: free-running wrapping counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 3'd0;
    else      q <= updown ? q + 3'd1 : q - 3'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold a button from just before edge 1 and check the exact edge where updown moves
  task automatic timed_press(input logic u, input logic d, input logic exp_dir, input string tag);
    up_btn = u;
    dn_btn = d;
    for (int e = 1; e < LAT; e++) begin
      tick();
      check_eq({tag, "_wait"}, {updown, dir_chg}, {~exp_dir, 1'b0});
    end
    tick();
    check_eq({tag, "_edge"}, {updown, dir_chg}, {exp_dir, 1'b1});
    tick();
    check_eq({tag, "_after"}, {updown, dir_chg}, {exp_dir, 1'b0});
    up_btn = 1'b0;
    dn_btn = 1'b0;
    for (int e = 0; e < LAT + 3; e++) tick();
    check_eq({tag, "_settle"}, {31'd0, updown}, {31'd0, exp_dir});
  endtask

  // press, release, and check final direction plus number of dir_chg pulses seen
  task automatic press_chk(input logic u, input logic d, input logic exp_dir,
                           input int exp_pulses, input string tag);
    int pulses;
    pulses = 0;
    up_btn = u;
    dn_btn = d;
    for (int e = 0; e < LAT + 2; e++) begin
      tick();
      if (dir_chg) pulses++;
    end
    up_btn = 1'b0;
    dn_btn = 1'b0;
    for (int e = 0; e < LAT + 3; e++) begin
      tick();
      if (dir_chg) pulses++;
    end
    check_eq({tag, "_dir"}, {31'd0, updown}, {31'd0, exp_dir});
    check_eq({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  initial begin
    int pulses;
    int m;
    int exp_q;
    logic found;

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check_eq("rst_async", {updown, dir_chg}, 2'b10);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_hold", {updown, dir_chg}, 2'b10);
    end

    // manual down then up with exact latency
    timed_press(1'b0, 1'b1, 1'b0, "man_dn");
    timed_press(1'b1, 1'b0, 1'b1, "man_up");

    // two-cycle glitch on dn_btn
    pulses = 0;
    dn_btn = 1'b1;
    tick();
    tick();
    dn_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dir_chg) pulses++;
    end
`ifdef UPDOWN_CTRL_DEBOUNCE_EN
    check_eq("glitch_dir", {31'd0, updown}, 32'd1);
    check_eq("glitch_pulses", pulses, 32'd0);
`else
    check_eq("glitch_dir", {31'd0, updown}, 32'd0);
    check_eq("glitch_pulses", pulses, 32'd1);
    press_chk(1'b1, 1'b0, 1'b1, 1, "restore_up");
`endif

    // go DN, then simultaneous requests and a same-direction request must not move it
    press_chk(1'b0, 1'b1, 1'b0, 1, "to_dn");
    press_chk(1'b1, 1'b1, 1'b0, 0, "both");
    press_chk(1'b0, 1'b1, 1'b0, 0, "same_dir");

    // ping-pong from reset: triangle 0..7..0 with period 14
    #2 rst = 1'b0;
    mode = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      m = n % 14;
      exp_q = (m <= 7) ? m : 14 - m;
      check_eq("pp_q", {29'd0, q}, exp_q);
      check_eq("pp_updown", {31'd0, updown}, {31'd0, (m < 7)});
      check_eq("pp_dir_chg", {31'd0, dir_chg}, {31'd0, (m == 7) || (m == 0)});
    end

    // reset in the middle of a downward sweep at q=5
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (q == 3'd5 && !updown) found = 1'b1;
    end
    check_eq("find_q5_dn", {31'd0, found}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_out", {updown, dir_chg}, 2'b10);
    check_eq("mid_rst_q", {29'd0, q}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("restart_q1", {29'd0, q}, 32'd1);
    tick();
    check_eq("restart_q2", {29'd0, q}, 32'd2);
    check_eq("restart_up", {updown, dir_chg}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_ctrl.md
# updown_ctrl

Direction controller that drives the `updown` input of the 3-bit synchronous up/down counter (`sync_updown`). It sits directly upstream of the counter and reads the counter's `q` back.
- Manual mode: two asynchronous push-buttons (up, down) are synchronized, debounced and edge-detected to set the count direction.
- Ping-pong mode: the block reverses direction one count before each terminal value, so the counter sweeps 0→max→0 without wrapping.

## Interface
Parameters:
- `WIDTH`, 3: counter width; must match the counter's `q`.
- `DB_CYCLES`, 4: consecutive stable cycles required before a debounced level changes; ≥2.

Ports:
- `clk`  in  1  rising-edge clock shared with the counter.
- `rst`  in  1  asynchronous, active-low reset. Asserted when 0.
- `up_btn`  in  1  asynchronous button; a rising edge requests count-up.
- `dn_btn`  in  1  asynchronous button; a rising edge requests count-down.
- `mode`  in  1  0 = manual, 1 = ping-pong. Synchronous, quasi-static.
- `q`  in  WIDTH  counter value fed back from `sync_updown`.
- `updown`  out  1  direction to the counter: 1 = up, 0 = down. Registered.
- `dir_chg`  out  1  one-cycle pulse in the cycle after `updown` toggles.

## Operation
- Reset (`rst`=0, async): `updown`=1 and `dir_chg`=0. Synchronizer flops, debounced levels, edge-detect flops and debounce counters all clear to 0.
- Synchronizer: 2-flop chain per button.
- Debouncer, per button:
  - Counter `cnt` counts consecutive cycles in which the synchronized level differs from the debounced level `deb`.
  - When `cnt`==DB_CYCLES-1 and the levels still differ, `deb` flips on that edge and `cnt` clears.
  - Any cycle where the levels match clears `cnt`.
- Edge detect: `rise = deb & ~deb_d`, where `deb_d` is `deb` delayed one cycle. A falling edge produces no request.
- Direction FSM has two states, UP (`updown`=1) and DN (`updown`=0).
  - Manual (`mode`=0):
    - `up_rise` alone → UP. `dn_rise` alone → DN.
    - Both in the same cycle → hold the current state.
    - A request for the current direction → no change, no `dir_chg`.
  - Ping-pong (`mode`=1):
    - In UP with `q` ≥ 2^WIDTH−2 → DN.
    - In DN with `q` ≤ 1 → UP.
    - Buttons are ignored, but the debouncers keep running.
- `mode` changes take effect on the next edge; the current direction is kept across the switch.
- `dir_chg` is registered: 1 iff `updown` changed on the previous edge.

## Timing
- Buttons, `UPDOWN_CTRL_DEBOUNCE_EN` defined, `DB_CYCLES`=4. Button held high before edge 1:
  - synchronized level high after edge 2;
  - `deb` rises at edge 6;
  - `updown` changes at edge 7;
  - `dir_chg`=1 for the cycle after edge 7.
- A pulse shorter than DB_CYCLES synchronized cycles is filtered completely.
- Ping-pong with the counter's reset value of 0 and WIDTH=3: `updown` is sampled registered, so the counter sequence is 0,1,…,6,7,6,…,1,0,1,… with no 7→0 or 0→7 wrap.
  - `updown` falls at the edge where `q` goes 6→7.
  - `updown` rises at the edge where `q` goes 1→0.
- Entering ping-pong while `q`=7 in UP: `updown` falls at the next edge. This can leave one wrap to 0, which is accepted; the sweep then resumes.
- Reset asserted mid-operation clears everything immediately, with no clock needed. The first request after release is subject to the full synchronizer and debounce latency.

## Configuration
- `UPDOWN_CTRL_DEBOUNCE_EN` defined: the debouncers are built as described above.
- Not defined: `deb` is the synchronizer output directly and no counters are built. A button held from before edge 1 changes `updown` at edge 3, and glitches are not filtered.
- FSM, ping-pong and `dir_chg` behaviour are identical in both builds.

## Test plan
- Reset: drive `rst`=0 between clock edges → `updown`=1 and `dir_chg`=0 immediately. Release, all inputs 0 → `updown` stays 1 for 20 cycles.
- Manual down then up (debounce on, `DB_CYCLES`=4):
  - `dn_btn` high from before edge 1 → `updown`=0 after edge 7, `dir_chg` pulses once.
  - Then `up_btn` → `updown`=1 after the same 7-edge latency.
- Glitch filter: `dn_btn` high for 2 cycles → `updown` stays 1 and `dir_chg` stays 0.
- Simultaneous requests: `up_btn` and `dn_btn` rise on the same edge while in DN → `updown` stays 0 and `dir_chg` stays 0.
- Ping-pong with the real counter, `mode`=1 from reset → `q` follows 0..7..0..7 over 30 cycles, never wraps, and `dir_chg` pulses at the 6→7 and 1→0 transitions.
- Reset mid-sweep: assert `rst` while `q`=5 in DN → `updown`=1 at once. After release the sweep restarts upward from `q`=0.
